// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared encodings for the CPU memory-op sequencer.
//
// Contents:
//   op_kind_e : execute-stage memory operation encoding (ld, st, ldp, stp).
//   state_e   : mem_op_seq FSM states. The paired-access states exist only
//               when MEM_OP_SEQ_PAIR_EN is defined.
//
// Build option: MEM_OP_SEQ_PAIR_EN enables the ldp/stp paired operations.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_LD  = 2'b00,
        OP_ST  = 2'b01,
        OP_LDP = 2'b10,
        OP_STP = 2'b11
    } op_kind_e;

`ifdef MEM_OP_SEQ_PAIR_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD1  = 3'd1,
        LD2  = 3'd2,
        LDP1 = 3'd3,
        LDP2 = 3'd4,
        LDP3 = 3'd5,
        STP2 = 3'd6
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD1  = 2'd1,
        LD2  = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/mem_op_seq.sv
// mem_op_seq -- sequences execute-stage memory operations onto a
// single-read/single-write data memory and the register writeback port.
//
// Build option: MEM_OP_SEQ_PAIR_EN adds ldp/stp (paired word accesses at
// op_addr and op_addr+1, registers op_rt and op_rt+1). Without it, ldp/stp
// are rejected with a one-cycle illegal_op + op_ack pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op_valid, op_kind     memory op request and its kind (cpu_pkg::op_kind_e)
//   flush                 pipeline flush; blocks acceptance this cycle
//   op_addr, op_rt        base word address and target/source register
//   st_data               store data read from the register chosen by src_sel
//   src_sel               0 = register op_rt, 1 = register op_rt+1
//   mem_raddr             data memory read address
//   mem_wen/waddr/wdata   data memory write port
//   wb_en/addr/from_mem   register writeback control
//   stall_fetch           hold PC/fetch this cycle (combinational)
//   stall_hold            hold fetched instruction (stall_fetch delayed 1)
//   op_ack, illegal_op    op completes this cycle / op was rejected
//   state_dbg             current FSM state, for observation only
//
// Handshake: upstream raises op_valid and holds op_kind/op_addr/op_rt until
// the cycle in which op_ack=1; the op is accepted only in IDLE with flush=0
// and is then never aborted (except by reset). op_valid is ignored outside
// IDLE, so the held op cannot be accepted twice.
module mem_op_seq
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op_kind,
    input  logic              flush,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [REG_AW-1:0] op_rt,
    input  logic [15:0]       st_data,
    output logic              src_sel,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [15:0]       mem_wdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic              wb_from_mem,
    output logic              stall_fetch,
    output logic              stall_hold,
    output logic              op_ack,
    output logic              illegal_op,
    output state_e            state_dbg
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [REG_AW-1:0] rt_q;
    logic              accept;

    // IDLE outputs depend on op_valid combinationally, so reset must gate
    // acceptance directly to keep every enable low while rst_n is low.
    assign accept    = rst_n && (state_q == IDLE) && op_valid && !flush;
    assign state_dbg = state_q;

`ifdef MEM_OP_SEQ_PAIR_EN
    logic [ADDR_W-1:0] addr_inc;
    logic [REG_AW-1:0] rt_inc;

    // Natural-width adds wrap modulo 2^ADDR_W and 2^REG_AW.
    assign addr_inc = addr_q + 1'b1;
    assign rt_inc   = rt_q + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rt_q       <= '0;
            stall_hold <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_hold <= stall_fetch;
            // Later accesses of a multi-cycle op use these captured copies.
            if (accept) begin
                addr_q <= op_addr;
                rt_q   <= op_rt;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        src_sel     = 1'b0;
        mem_raddr   = '0;
        mem_wen     = 1'b0;
        mem_waddr   = '0;
        mem_wdata   = st_data;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_from_mem = 1'b0;
        stall_fetch = 1'b0;
        op_ack      = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_kind)
                        OP_LD: begin
                            stall_fetch = 1'b1;
                            state_d     = LD1;
                        end
                        OP_ST: begin
                            mem_wen   = 1'b1;
                            mem_waddr = op_addr;
                            op_ack    = 1'b1;
                        end
`ifdef MEM_OP_SEQ_PAIR_EN
                        OP_LDP: begin
                            stall_fetch = 1'b1;
                            state_d     = LDP1;
                        end
                        OP_STP: begin
                            mem_wen     = 1'b1;
                            mem_waddr   = op_addr;
                            stall_fetch = 1'b1;
                            state_d     = STP2;
                        end
                        default: ;
`else
                        default: begin
                            illegal_op = 1'b1;
                            op_ack     = 1'b1;
                        end
`endif
                    endcase
                end
            end
            LD1: begin
                mem_raddr = addr_q;
                state_d   = LD2;
            end
            LD2: begin
                wb_en       = 1'b1;
                wb_from_mem = 1'b1;
                wb_addr     = rt_q;
                op_ack      = 1'b1;
                state_d     = IDLE;
            end
`ifdef MEM_OP_SEQ_PAIR_EN
            LDP1: begin
                mem_raddr = addr_q;
                state_d   = LDP2;
            end
            LDP2: begin
                wb_en       = 1'b1;
                wb_from_mem = 1'b1;
                wb_addr     = rt_q;
                mem_raddr   = addr_inc;
                state_d     = LDP3;
            end
            LDP3: begin
                wb_en       = 1'b1;
                wb_from_mem = 1'b1;
                wb_addr     = rt_inc;
                op_ack      = 1'b1;
                state_d     = IDLE;
            end
            STP2: begin
                src_sel   = 1'b1;
                mem_wen   = 1'b1;
                mem_waddr = addr_inc;
                op_ack    = 1'b1;
                state_d   = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
